lc3_mem_responder: RTL and testbench

Parametrised multi-channel memory responder for the LC-3 environment. It serves the instruction-fetch and data-access ports of the LC-3 core with configurable width, depth, channel count and fixed access latency. It generalises the single instruction/data pair into N independent request/complete channels over one shared word array. It sits between the core's memory ports (pc/instrmem_rd, Data_addr/Data_rd/Data_din) and their Instr_dout/Data_dout/complete_* returns.

---
 rtl/lc3_mem_responder_if.sv | 35 +++
 rtl/lc3_mem_responder.sv | 150 +++++++++++++++
 tb/tb_lc3_mem_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_responder_if.sv
// rtl/lc3_mem_responder_if.sv - Per-channel request/complete bus between LC-3 memory ports and the responder
//
// Signals (channel c occupies bit c, or the slice [c*W +: W] of packed vectors):
//   req       requester -> responder   request strobe
//   rd        requester -> responder   1 = read, 0 = write
//   addr      requester -> responder   word address, AW bits per channel
//   din       requester -> responder   write data, DW bits per channel
//   dout      responder -> requester   read data, DW bits per channel
//   complete  responder -> requester   one-cycle access-finished pulse
//   busy      responder -> requester   accepted request not yet finished
// Modports: master (requester side), slave (responder side).

interface lc3_mem_responder_if #(
    parameter int N_CH = 2,
    parameter int AW   = 16,
    parameter int DW   = 16
);
    logic [N_CH-1:0]    req;
    logic [N_CH-1:0]    rd;
    logic [N_CH*AW-1:0] addr;
    logic [N_CH*DW-1:0] din;
    logic [N_CH*DW-1:0] dout;
    logic [N_CH-1:0]    complete;
    logic [N_CH-1:0]    busy;

    modport master (
        output req, rd, addr, din,
        input  dout, complete, busy
    );

    modport slave (
        input  req, rd, addr, din,
        output dout, complete, busy
    );
endinterface

// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - Multi-channel fixed-latency memory responder over one shared word array
//
// Ports:
//   clk    clock, all state on the rising edge
//   reset  asynchronous active-low reset; clears FSMs, outputs and the whole array
//   bus    lc3_mem_responder_if.slave: per-channel req/rd/addr/din in, dout/complete/busy out
// Parameters: DW data width, AW address width, DEPTH words (power of 2),
//   N_CH channels (ch0 instruction, ch1 data), LATENCY accept-to-complete cycles (>= 1).
// Optional build macro: LC3_MEM_STALL_EN adds a per-channel LFSR that stretches each
//   request by 0-3 extra cycles.

module lc3_mem_responder #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int DEPTH   = 256,
    parameter int N_CH    = 2,
    parameter int LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    lc3_mem_responder_if.slave    bus
);

    localparam int IW = $clog2(DEPTH);
`ifdef LC3_MEM_STALL_EN
    localparam int CW = $clog2(LATENCY + 4);
`else
    localparam int CW = $clog2(LATENCY + 1);
`endif

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state_q [N_CH];
    state_t          state_d [N_CH];
    logic [CW-1:0]   cnt_q   [N_CH];
    logic [CW-1:0]   cnt_d   [N_CH];
    logic [CW-1:0]   load    [N_CH];
    logic [N_CH-1:0] accept;
    logic [N_CH-1:0] finish;

    logic [N_CH-1:0] rd_q;
    logic [IW-1:0]   idx_q   [N_CH];
    logic [DW-1:0]   wdata_q [N_CH];

    logic [DW-1:0]   mem     [DEPTH];
    logic [DW-1:0]   dout_q  [N_CH];
    logic [N_CH-1:0] complete_q;

    // Address bits above the array index are deliberately ignored (accesses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr;

`ifdef LC3_MEM_STALL_EN
    logic [3:0] lfsr_q [N_CH];

    // Fibonacci LFSR, taps 4,3; advances once per accepted request. The current
    // value's low bits stretch the request being accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < N_CH; c++) lfsr_q[c] <= 4'b1001 ^ 4'(c);
        end else begin
            for (int c = 0; c < N_CH; c++)
                if (accept[c]) lfsr_q[c] <= {lfsr_q[c][2:0], lfsr_q[c][3] ^ lfsr_q[c][2]};
        end
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) load[c] = CW'(LATENCY - 1) + CW'(lfsr_q[c][1:0]);
    end
`else
    always_comb begin
        for (int c = 0; c < N_CH; c++) load[c] = CW'(LATENCY - 1);
    end
`endif

    // Next-state logic. A channel finishing this edge is free again, so a request
    // presented in its completion cycle is accepted and the channel stays in WAIT.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            finish[c]  = 1'b0;
            accept[c]  = 1'b0;

            finish[c] = (state_q[c] == WAIT) && (cnt_q[c] == '0);
            accept[c] = bus.req[c] && ((state_q[c] == IDLE) || finish[c]);

            if (accept[c]) begin
                state_d[c] = WAIT;
                cnt_d[c]   = load[c];
            end else if (finish[c]) begin
                state_d[c] = IDLE;
            end else if (state_q[c] == WAIT) begin
                cnt_d[c] = cnt_q[c] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= IDLE;
                cnt_q[c]   <= '0;
                idx_q[c]   <= '0;
                wdata_q[c] <= '0;
            end
            rd_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                if (accept[c]) begin
                    rd_q[c]    <= bus.rd[c];
                    idx_q[c]   <= bus.addr[c*AW +: IW];
                    wdata_q[c] <= bus.din[c*DW +: DW];
                end
            end
        end
    end

    // Ascending channel order: the last non-blocking write to an index wins,
    // so the highest channel takes precedence on a collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++)
                if (finish[c] && !rd_q[c]) mem[idx_q[c]] <= wdata_q[c];
        end
    end

    // Reads sample the array before this edge's writes land: read-before-write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < N_CH; c++) dout_q[c] <= '0;
            complete_q <= '0;
        end else begin
            complete_q <= finish;
            for (int c = 0; c < N_CH; c++)
                if (finish[c] && rd_q[c]) dout_q[c] <= mem[idx_q[c]];
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_out
        assign bus.dout[c*DW +: DW] = dout_q[c];
        assign bus.busy[c]          = (state_q[c] == WAIT);
    end
    assign bus.complete = complete_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb/tb_lc3_mem_responder.sv - Scoreboard bench for lc3_mem_responder (N_CH=2, DEPTH=256, LATENCY=3)

module tb_lc3_mem_responder;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lc3_mem_responder_if #(.N_CH(2), .AW(16), .DW(16)) bus ();

    lc3_mem_responder #(
        .DW(16), .AW(16), .DEPTH(256), .N_CH(2), .LATENCY(LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          ch;
        int          cyc;
        bit          is_rd;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int find_ch(input int ch);
        foreach (sb[i]) if (sb[i].ch == ch) return i;
        return -1;
    endfunction

    // Monitor: every completion must match the oldest expectation for its channel.
    always @(negedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                int   idx;
                exp_t e;
                idx = find_ch(ch);
                if (bus.complete[ch]) begin
                    if (idx < 0) begin
                        chk($sformatf("ch%0d unexpected complete", ch), 32'd1, 32'd0);
                    end else begin
                        e = sb[idx];
                        sb.delete(idx);
                        chk($sformatf("ch%0d complete cycle", ch), cyc, e.cyc);
                        if (e.is_rd)
                            chk($sformatf("ch%0d read data", ch), {16'h0, bus.dout[ch*16 +: 16]}, {16'h0, e.data});
                    end
                end else if (idx >= 0 && cyc >= sb[idx].cyc) begin
                    chk($sformatf("ch%0d missing complete", ch), 32'd0, 32'd1);
                    sb.delete(idx);
                end
            end
        end
    end

    // Drive one channel's request for the next edge; optionally record its expected result.
    task automatic set_req(input int ch, input bit r, input logic [15:0] a, input logic [15:0] d,
                           input bit expect_it, input logic [15:0] exp_data);
        exp_t e;
        bus.req[ch]           = 1'b1;
        bus.rd[ch]            = r;
        bus.addr[ch*16 +: 16] = a;
        bus.din[ch*16 +: 16]  = d;
        if (expect_it) begin
            e.ch    = ch;
            e.cyc   = cyc + 1 + LAT;
            e.is_rd = r;
            e.data  = exp_data;
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        bus.req = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " complete"}, {30'h0, bus.complete}, 32'h0);
        chk({tag, " busy"},     {30'h0, bus.busy},     32'h0);
        chk({tag, " dout"},     bus.dout,              32'h0);
    endtask

    initial begin
        bus.req  = '0;
        bus.rd   = '0;
        bus.addr = '0;
        bus.din  = '0;

        // Reset held for three cycles, then idle.
        repeat (3) @(negedge clk);
        chk_quiet("in reset");
        reset = 1'b1;
        idle(2);
        chk_quiet("idle after reset");

        // ch1 write 0xBEEF @0x0010, read back-to-back in the write's completion cycle.
        set_req(1, 1'b0, 16'h0010, 16'hBEEF, 1'b1, 16'h0);
        step();
        chk("busy after accept", {31'h0, bus.busy[1]}, 32'd1);
        step();
        step();
        set_req(1, 1'b1, 16'h0010, 16'h0, 1'b1, 16'hBEEF);
        step();
        chk("busy kept by back-to-back accept", {31'h0, bus.busy[1]}, 32'd1);
        idle(LAT + 1);

        // Address wrap: 0x0105 and 0x0005 share index 5.
        set_req(0, 1'b0, 16'h0105, 16'h1234, 1'b1, 16'h0);
        step();
        idle(LAT + 1);
        set_req(0, 1'b1, 16'h0005, 16'h0, 1'b1, 16'h1234);
        step();
        idle(LAT + 1);

        // Same-cycle write collision: higher channel wins.
        set_req(0, 1'b0, 16'h0020, 16'hAAAA, 1'b1, 16'h0);
        set_req(1, 1'b0, 16'h0020, 16'h5555, 1'b1, 16'h0);
        step();
        idle(LAT + 1);
        set_req(0, 1'b1, 16'h0020, 16'h0, 1'b1, 16'h5555);
        step();
        idle(LAT + 1);

        // Read and write to one index completing together: read sees the old value.
        set_req(0, 1'b0, 16'h0030, 16'h1111, 1'b1, 16'h0);
        step();
        idle(LAT + 1);
        set_req(0, 1'b1, 16'h0030, 16'h0, 1'b1, 16'h1111);
        set_req(1, 1'b0, 16'h0030, 16'h2222, 1'b1, 16'h0);
        step();
        idle(LAT + 1);
        set_req(1, 1'b1, 16'h0030, 16'h0, 1'b1, 16'h2222);
        step();
        idle(LAT + 1);

        // Request while busy is dropped; request in the completion cycle is taken.
        set_req(0, 1'b1, 16'h0030, 16'h0, 1'b1, 16'h2222);
        step();
        set_req(0, 1'b0, 16'h0040, 16'h9999, 1'b0, 16'h0);
        step();
        step();
        set_req(0, 1'b1, 16'h0010, 16'h0, 1'b1, 16'hBEEF);
        step();
        idle(LAT + 1);
        set_req(1, 1'b1, 16'h0040, 16'h0, 1'b1, 16'h0000);
        step();
        idle(LAT + 1);

        // Reset mid-operation: the pending write is abandoned and the array clears.
        set_req(1, 1'b0, 16'h0003, 16'h7777, 1'b0, 16'h0);
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk_quiet("mid-op reset");
        reset = 1'b1;
        idle(LAT + 2);
        set_req(1, 1'b1, 16'h0003, 16'h0, 1'b1, 16'h0000);
        set_req(0, 1'b1, 16'h0020, 16'h0, 1'b1, 16'h0000);
        step();
        idle(LAT + 2);

        chk("scoreboard drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
